// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared definitions for the UART receive frame controller: frame geometry and FSM encoding.
package uart_rx_frame_ctrl_pkg;

    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;

    // Sample index of the parity bit inside the DATA state (data bits occupy 0..7)
    localparam logic [3:0] LAST_BIT_IDX = 4'(DATA_BITS);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_t;

endpackage

// File: rtl/uart_rx_frame_ctrl_sync.sv
// Multi-flop synchroniser for the asynchronous rx line; resets to the idle (high) level.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) chain <= '1;
        else     chain <= {chain[SYNC_STAGES-2:0], rx};
    end

    assign rx_s = chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART frame receiver: start-bit detection, mid-bit sampling and 11-bit frame capture.
// Frame buffer only updates on the stop sample so downstream never sees a partial frame.
module uart_rx_frame_ctrl
    import uart_rx_frame_ctrl_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [FRAME_BITS-1:0] buffer,
    output logic                  frame_valid,
    output logic                  framing_error,
    output logic                  busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_TC  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic                  rx_s;
    state_t                state, state_nx;
    logic [CNT_W-1:0]      cnt, cnt_nx;
    logic [3:0]            bitidx, bitidx_nx;
    logic [FRAME_BITS-2:0] shift_reg, shift_nx;
    logic [FRAME_BITS-1:0] buffer_nx;
    logic                  fv_nx, fe_nx, busy_nx;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rx_s (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            bitidx        <= '0;
            shift_reg     <= '0;
            buffer        <= '0;
            frame_valid   <= 1'b0;
            framing_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            bitidx        <= bitidx_nx;
            shift_reg     <= shift_nx;
            buffer        <= buffer_nx;
            frame_valid   <= fv_nx;
            framing_error <= fe_nx;
            busy          <= busy_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        bitidx_nx = bitidx;
        shift_nx  = shift_reg;
        buffer_nx = buffer;
        fv_nx     = 1'b0;
        fe_nx     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_nx = ST_START;
                    cnt_nx   = '0;
                end
            end
            ST_START: begin
                if (cnt == HALF_TC) begin
                    if (rx_s) begin
                        state_nx = ST_IDLE;
                    end else begin
                        shift_nx  = {shift_reg[FRAME_BITS-3:0], 1'b0};
                        cnt_nx    = '0;
                        bitidx_nx = '0;
                        state_nx  = ST_DATA;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt == BIT_TC) begin
                    shift_nx  = {shift_reg[FRAME_BITS-3:0], rx_s};
                    cnt_nx    = '0;
                    bitidx_nx = bitidx + 4'd1;
                    if (bitidx == LAST_BIT_IDX) state_nx = ST_STOP;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt == BIT_TC) begin
                    shift_nx  = {shift_reg[FRAME_BITS-3:0], rx_s};
                    buffer_nx = {shift_reg, rx_s};
                    fv_nx     = 1'b1;
                    fe_nx     = ~rx_s;
                    cnt_nx    = '0;
                    // Returning straight to IDLE lets a start bit directly after stop be taken
                    state_nx  = rx_s ? ST_IDLE : ST_WAIT_HIGH;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase

        busy_nx = (state_nx == ST_START) || (state_nx == ST_DATA) || (state_nx == ST_STOP);
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: directed frame scenarios plus random traffic
// scored against a serial-frame model built from the line bit sequence.
module tb_uart_rx_frame_ctrl;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic [10:0] buffer;
    logic        frame_valid;
    logic        framing_error;
    logic        busy;

    uart_rx_frame_ctrl #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .buffer        (buffer),
        .frame_valid   (frame_valid),
        .framing_error (framing_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] frame;
        logic        fe;
    } exp_t;

    exp_t        expq[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          fv_count = 0;
    int          fv_cycle_last = 0;
    int          fv_cycle_prev = 0;
    logic [10:0] last_exp_buf = '0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Model: the line carries start, D0..D7, parity, stop; each bit shifts in at the LSB.
    function automatic logic [10:0] model_frame(input logic [7:0] d, input logic par, input logic stp);
        logic [10:0] acc;
        logic        bits[11];
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        bits[9]  = par;
        bits[10] = stp;
        acc = '0;
        for (int i = 0; i < 11; i++) acc = {acc[9:0], bits[i]};
        return acc;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (framing_error) check_val("fe_with_fv", frame_valid, 1);
            if (frame_valid) begin
                fv_count++;
                fv_cycle_prev = fv_cycle_last;
                fv_cycle_last = cyc;
                if (expq.size() == 0) begin
                    check_val("frame_expected", 0, 1);
                end else begin
                    e = expq.pop_front();
                    check_val("buffer", buffer, e.frame);
                    check_val("framing_error", framing_error, e.fe);
                end
            end
        end
    end

    task automatic drive_bit(input logic b, input int n);
        rx = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        exp_t e;
        e.frame = model_frame(d, par, stp);
        e.fe    = ~stp;
        expq.push_back(e);
        last_exp_buf = e.frame;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
        drive_bit(par, CPB);
        drive_bit(stp, CPB);
    endtask

    task automatic idle(input int n);
        drive_bit(1'b1, n);
    endtask

    initial begin
        int          t0, n0, gap;
        logic [7:0]  d;
        logic        par, stp;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_buffer", buffer, 11'h000);
        check_val("rst_fv", frame_valid, 0);
        check_val("rst_fe", framing_error, 0);
        check_val("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(10);

        // 1: clean 0xA5; sync(2) + IDLE detect(1) + 10.5 bit periods = 171 cycles
        t0 = cyc;
        fork
            send_frame(8'hA5, 1'b0, 1'b1);
            begin
                repeat (40) @(posedge clk);
                @(negedge clk);
                check_val("busy_mid_frame", busy, 1);
            end
        join
        idle(20);
        check_val("fv_latency", fv_cycle_last - t0, 171);
        check_val("a5_buffer_model", last_exp_buf, 11'h295);

        // 2: stop bit low, line held low afterwards
        n0 = fv_count;
        send_frame(8'h01, 1'b1, 1'b0);
        drive_bit(1'b0, 80);
        @(negedge clk);
        check_val("busy_wait_high", busy, 0);
        check_val("no_rearm_low", fv_count - n0, 1);
        idle(20);

        // 3: short glitch must be rejected
        n0 = fv_count;
        drive_bit(1'b0, 5);
        drive_bit(1'b1, 9);
        @(negedge clk);
        check_val("glitch_busy", busy, 0);
        idle(30);
        check_val("glitch_no_frame", fv_count - n0, 0);
        check_val("glitch_buffer", buffer, last_exp_buf);

        // 4: back-to-back frames with no idle gap
        send_frame(8'h3C, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle(20);
        check_val("b2b_spacing", fv_cycle_last - fv_cycle_prev, 176);

        // 5: reset during D4 discards the partial frame
        n0 = fv_count;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, CPB);
        drive_bit(1'b0, CPB / 2);
        rst = 1'b1;
        @(negedge clk);
        check_val("midrst_buffer", buffer, 11'h000);
        check_val("midrst_fv", frame_valid, 0);
        check_val("midrst_busy", busy, 0);
        @(posedge clk); #1;
        rx = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(200);
        check_val("midrst_no_frame", fv_count - n0, 0);
        send_frame(8'h5A, 1'b0, 1'b1);
        idle(20);

        // 6: wrong parity is passed through untouched
        send_frame(8'hA5, 1'b1, 1'b1);
        idle(20);

        // random traffic
        for (int k = 0; k < 30; k++) begin
            d   = 8'($urandom);
            par = ^d;
            if ($urandom_range(0, 3) == 0) par = ~par;
            stp = ($urandom_range(0, 4) != 0);
            send_frame(d, par, stp);
            if (!stp) begin
                gap = $urandom_range(0, 40);
                if (gap > 0) drive_bit(1'b0, gap);
                idle($urandom_range(4, 20));
            end else begin
                gap = $urandom_range(0, 20);
                if (gap > 0) idle(gap);
            end
        end
        idle(40);
        check_val("pending_frames", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
